// File: rtl/alu_wb_stage.sv
// Writeback stage behind the ALU: in-order result FIFO, register-file handshake,
// RAW pending-write lookup and overflow status. Optional macro: ALU_WB_OVERFLOW_TRAP_EN.
module alu_wb_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic              in_overflow,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic              in_wen,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic              wb_en,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   input  logic [ADDR_W-1:0] chk_addr,
   output logic              chk_hit,
   input  logic              clr_status,
   output logic              ovf_sticky,
   output logic [7:0]        ovf_count,
   output logic              trap,
   output logic              busy
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [DEPTH-1:0]  valid_q;
   logic [DATA_W-1:0] res_q [DEPTH];
   logic [ADDR_W-1:0] rd_q  [DEPTH];
   logic              wen_q [DEPTH];
`ifdef ALU_WB_OVERFLOW_TRAP_EN
   // Only the trap build consumes the per-entry overflow flag.
   logic              ovf_q [DEPTH];
   logic              trap_q;
`endif

   logic push, pop, empty, full;
   logic [DEPTH-1:0] hit_vec;

   logic       ovf_sticky_q, ovf_sticky_d;
   logic [7:0] ovf_count_q, ovf_count_d, count_base;

   assign empty    = ~|valid_q;
   assign full     = &valid_q;
   assign in_ready = ~full;
   assign push     = in_valid & ~full;
   assign pop      = ~empty & wb_ready;
   assign busy     = ~empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         valid_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            res_q[i] <= '0;
            rd_q[i]  <= '0;
            wen_q[i] <= 1'b0;
`ifdef ALU_WB_OVERFLOW_TRAP_EN
            ovf_q[i] <= 1'b0;
`endif
         end
      end else begin
         if (push) begin
            res_q[wr_ptr_q]   <= in_result;
            rd_q[wr_ptr_q]    <= in_rd;
            wen_q[wr_ptr_q]   <= in_wen;
`ifdef ALU_WB_OVERFLOW_TRAP_EN
            ovf_q[wr_ptr_q]   <= in_overflow;
`endif
            valid_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
         end
         // A push never lands on the head slot while it is being popped: not full implies wr != rd.
         if (pop) begin
            valid_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   always_comb begin
      wb_valid = ~empty;
      wb_en    = ~empty & wen_q[rd_ptr_q] & (rd_q[rd_ptr_q] != '0);
`ifdef ALU_WB_OVERFLOW_TRAP_EN
      wb_en    = wb_en & ~ovf_q[rd_ptr_q];
`endif
      wb_addr  = empty ? '0 : rd_q[rd_ptr_q];
      wb_data  = empty ? '0 : res_q[rd_ptr_q];
   end

   always_comb begin
      hit_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hit_vec[i] = valid_q[i] & wen_q[i] & (rd_q[i] != '0) & (rd_q[i] == chk_addr);
`ifdef ALU_WB_OVERFLOW_TRAP_EN
         hit_vec[i] = hit_vec[i] & ~ovf_q[i];
`endif
      end
      chk_hit = |hit_vec;
   end

   // Clear applies first so a coinciding overflow push leaves a count of one.
   always_comb begin
      ovf_sticky_d = ovf_sticky_q;
      count_base   = clr_status ? 8'd0 : ovf_count_q;
      ovf_count_d  = count_base;
      if (clr_status) ovf_sticky_d = 1'b0;
      if (push && in_overflow) begin
         ovf_sticky_d = 1'b1;
         if (count_base != 8'hFF) ovf_count_d = count_base + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky_q <= 1'b0;
         ovf_count_q  <= 8'd0;
      end else begin
         ovf_sticky_q <= ovf_sticky_d;
         ovf_count_q  <= ovf_count_d;
      end
   end

   assign ovf_sticky = ovf_sticky_q;
   assign ovf_count  = ovf_count_q;

`ifdef ALU_WB_OVERFLOW_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) trap_q <= 1'b0;
      else        trap_q <= pop & ovf_q[rd_ptr_q];
   end
   assign trap = trap_q;
`else
   assign trap = 1'b0;
`endif

endmodule
